// File: rtl/layer1_window_buffer.sv
// Streaming 3x3x3 window generator for the layer-1 PE: two line buffers per channel
// plus a 3-column shift window, emitting one registered window per valid conv position.
module layer1_window_buffer #(
    parameter int IMG_W = 30,
    parameter int IMG_H = 30,
    parameter int DW    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   pix_c1,
    input  logic [DW-1:0]   pix_c2,
    input  logic [DW-1:0]   pix_c3,
    output logic [9*DW-1:0] win_c1,
    output logic [9*DW-1:0] win_c2,
    output logic [9*DW-1:0] win_c3,
    output logic            win_valid,
    output logic            frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = 3 * DW;
    localparam int WW = 9 * DW;

    // Shift a window left by one column; t/m/b become the new newest column (elements 3/6/9).
    function automatic logic [WW-1:0] shift_win(
        input logic [WW-1:0] w,
        input logic [DW-1:0] t,
        input logic [DW-1:0] m,
        input logic [DW-1:0] b
    );
        shift_win = {b, w[9*DW-1 -: DW], w[8*DW-1 -: DW],
                     m, w[6*DW-1 -: DW], w[5*DW-1 -: DW],
                     t, w[3*DW-1 -: DW], w[2*DW-1 -: DW]};
    endfunction

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    // Each line-buffer word carries all three channels of one column position.
    logic [PW-1:0] lb1_r [IMG_W];
    logic [PW-1:0] lb2_r [IMG_W];

    logic [WW-1:0] win_c1_r;
    logic [WW-1:0] win_c2_r;
    logic [WW-1:0] win_c3_r;
    logic          win_valid_r;
    logic          frame_done_r;

    logic [PW-1:0] pix_s;
    logic [PW-1:0] top_s;
    logic [PW-1:0] mid_s;
    logic          accept_s;
    logic          col_last_s;
    logic          row_last_s;
    logic          in_win_s;

    // Decode of the current raster position and line-buffer read data.
    always_comb begin
        pix_s      = {pix_c3, pix_c2, pix_c1};
        top_s      = lb2_r[col_r];
        mid_s      = lb1_r[col_r];
        accept_s   = in_valid & ~rst;
        col_last_s = (col_r == CW'(IMG_W - 1));
        row_last_s = (row_r == RW'(IMG_H - 1));
        in_win_s   = (row_r >= RW'(2)) && (col_r >= CW'(2));
    end

    // Raster position counters for the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (in_valid) begin
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Line buffers: contents are never observed before being rewritten, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_r[col_r] <= mid_s;
            lb1_r[col_r] <= pix_s;
        end
    end

    // Window shift registers double as the registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_c1_r <= '0;
            win_c2_r <= '0;
            win_c3_r <= '0;
        end else if (in_valid) begin
            win_c1_r <= shift_win(win_c1_r, top_s[0*DW +: DW], mid_s[0*DW +: DW], pix_s[0*DW +: DW]);
            win_c2_r <= shift_win(win_c2_r, top_s[1*DW +: DW], mid_s[1*DW +: DW], pix_s[1*DW +: DW]);
            win_c3_r <= shift_win(win_c3_r, top_s[2*DW +: DW], mid_s[2*DW +: DW], pix_s[2*DW +: DW]);
        end
    end

    // Single-cycle qualifiers for a complete window and for the frame's final window.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            win_valid_r  <= in_valid & in_win_s;
            frame_done_r <= in_valid & col_last_s & row_last_s;
        end
    end

    assign win_c1     = win_c1_r;
    assign win_c2     = win_c2_r;
    assign win_c3     = win_c3_r;
    assign win_valid  = win_valid_r;
    assign frame_done = frame_done_r;

endmodule
